serial_subtractor: RTL and testbench

- Multi-cycle, bit-serial subtractor. It computes Y = A - B - BorrowIN, one bit per clock, LSB first.
- It is the inverse-direction companion of the ripple-carry 4-bit adder in the ALU datapath.
- It reports BorrowOUT and signed overflow with the same meaning as the adder's overflow detection for the subtract opcode.
- Operands and result are exchanged through a start/busy/done handshake, so the ALU controller can share one 1-bit subtract cell across all bits.

---
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Y = A - B - BorrowIN, one bit per clock, LSB first,
// behind a start/busy/done handshake. Results update only on the completing edge.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowIN,
  output logic [WIDTH-1:0] Y,
  output logic             BorrowOUT,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             accept, last_bit;
  logic             a_i, b_i, d, br_next;
  logic [WIDTH-1:0] res_next;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  // One shared 1-bit subtract cell; operands shift right so bit i is always at [0].
  assign a_i      = a_sr[0];
  assign b_i      = b_sr[0];
  assign d        = a_i ^ b_i ^ br;
  assign br_next  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  assign res_next = {d, res_sr[WIDTH-1:1]};

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops sample
  // the pre-edge values of each other regardless of statement order.
  // NOTE: the shift registers are plain flops, not a memory, so they are reset
  // along with everything else to give a fully defined state after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      Y         <= '0;
      BorrowOUT <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_sr   <= A;
      b_sr   <= B;
      br     <= BorrowIN;
      res_sr <= '0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      br     <= br_next;
      res_sr <= res_next;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        // At the final bit a_i/b_i are the operand MSBs and d is the result MSB.
        Y         <= res_next;
        BorrowOUT <= br_next;
        overflow  <= (a_i ^ b_i) & (d ^ a_i);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: expected results are queued when an
// operation is started and popped when the design raises done.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             bo;
    logic             ov;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             BorrowIN = 1'b0;
  logic [WIDTH-1:0] Y;
  logic             BorrowOUT, overflow, busy, done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [WIDTH-1:0] last_y = '0;
  logic             last_bo = 1'b0;
  logic             last_ov = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .BorrowIN(BorrowIN),
    .Y(Y), .BorrowOUT(BorrowOUT), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    exp_t e;
    logic [WIDTH:0] full;
    full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    e.y  = full[WIDTH-1:0];
    e.bo = ({1'b0, a} < ({1'b0, b} + {{WIDTH{1'b0}}, bin}));
    e.ov = (a[WIDTH-1] != b[WIDTH-1]) && (e.y[WIDTH-1] != a[WIDTH-1]);
    sb.push_back(e);
  endtask

  // Presents operands with start high across one rising edge.
  task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    A = a; B = b; BorrowIN = bin; start = 1'b1;
    push_exp(a, b, bin);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits (bounded) for done; checks busy and output hold before it, then latency and result.
  task automatic wait_done(input string name, input int exp_lat);
    int  n = 0;
    bit  seen = 0;
    exp_t e;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      n = i;
      if (done) seen = 1;
      else begin
        checks++;
        if (busy !== 1'b1 || Y !== last_y || BorrowOUT !== last_bo || overflow !== last_ov) begin
          errors++;
          $display("FAIL %s_shift cyc%0d: busy=%b Y=%0d bo=%b ov=%b, need busy=1 Y=%0d bo=%b ov=%b",
                   name, i, busy, Y, BorrowOUT, overflow, last_y, last_bo, last_ov);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no done within 20 cycles", name);
      return;
    end
    checks++;
    if (n != exp_lat || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles busy=%b, need %0d busy=0", name, n, busy, exp_lat);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: done with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      if (Y !== e.y || BorrowOUT !== e.bo || overflow !== e.ov) begin
        errors++;
        $display("FAIL %s_result: Y=%0d bo=%b ov=%b, need Y=%0d bo=%b ov=%b",
                 name, Y, BorrowOUT, overflow, e.y, e.bo, e.ov);
      end
      last_y = e.y; last_bo = e.bo; last_ov = e.ov;
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || Y !== last_y || BorrowOUT !== last_bo || overflow !== last_ov) begin
        errors++;
        $display("FAIL %s cyc%0d: done=%b busy=%b Y=%0d bo=%b ov=%b, need 0 0 %0d %b %b",
                 name, i, done, busy, Y, BorrowOUT, overflow, last_y, last_bo, last_ov);
      end
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (Y !== '0 || BorrowOUT !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: Y=%0d bo=%b ov=%b busy=%b done=%b, need all 0",
               name, Y, BorrowOUT, overflow, busy, done);
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1 check_zero("reset_async");
    @(posedge clk);
    #1 rst = 1'b0;
    last_y = '0; last_bo = 1'b0; last_ov = 1'b0;
    check_quiet("reset_idle", 3);
  endtask

  task automatic test_basic();
    drive_start(4'd7, 4'd3, 1'b0);
    wait_done("basic_7m3", WIDTH + 1);
    check_quiet("basic_after", 1);
  endtask

  task automatic test_wrap();
    drive_start(4'd3, 4'd7, 1'b0);
    wait_done("wrap_3m7", WIDTH + 1);
    drive_start(4'd5, 4'd2, 1'b1);
    wait_done("bin_5m2m1", WIDTH + 1);
  endtask

  task automatic test_handshake();
    @(negedge clk);
    drive_start(4'd7, 4'd3, 1'b0);
    // Re-pulse start mid-SHIFT with different operands; must be ignored.
    @(negedge clk);
    A = 4'd1; B = 4'd1; BorrowIN = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignore_start", WIDTH);
    // Still in the DONE cycle: hold start high for a back-to-back operation.
    drive_start(4'd9, 4'd9, 1'b0);
    wait_done("back_to_back", WIDTH + 1);
  endtask

  task automatic test_overflow();
    drive_start(4'd7, 4'd8, 1'b0);
    wait_done("ovf_7m8", WIDTH + 1);
    drive_start(4'd8, 4'd1, 1'b0);
    wait_done("ovf_8m1", WIDTH + 1);
    for (int i = 0; i < 3; i++) begin
      drive_start(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      wait_done("random", WIDTH + 1);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_start(4'd6, 4'd1, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("reset_mid_async");
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    last_y = '0; last_bo = 1'b0; last_ov = 1'b0;
    check_quiet("reset_mid_nodone", 8);
    drive_start(4'd6, 4'd1, 1'b0);
    wait_done("after_reset", WIDTH + 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_handshake();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
